// File: rtl/hnoc_pkg.sv
// Shared definitions for the hierarchical NoC: packet layout and counter width.
package hnoc_pkg;
  localparam int PKT_W     = 32;
  localparam int DEST_W    = 8;
  localparam int PAYLOAD_W = 24;
  localparam int DEST_MSB  = 31;
  localparam int DEST_LSB  = 24;
  localparam int CNT_W     = 16;

  typedef struct packed {
    logic [DEST_W-1:0]    dest;
    logic [PAYLOAD_W-1:0] payload;
  } hnoc_pkt_t;
endpackage

// File: rtl/hnoc_fifo.sv
// Synchronous FIFO with wrapping pointers and an explicit fill count.
module hnoc_fifo
  import hnoc_pkg::*;
#(
  parameter int DATA_W = PKT_W,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       occupancy,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign occupancy = count;
  assign rd_data   = mem[rd_ptr];

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/hnoc_ingress.sv
// Per-PE ingress: buffers PE packets and steers the FIFO head to the local
// cluster switch or the uplink, counting deliveries in each direction.
module hnoc_ingress
  import hnoc_pkg::*;
#(
  parameter int fifoDepth   = 4,
  parameter int clusterBase = 0,
  parameter int clusterSize = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PKT_W-1:0]           i_data,
  input  logic                       i_data_valid,
  output logic                       o_data_ready,
  output logic [PKT_W-1:0]           o_local_data,
  output logic                       o_local_valid,
  input  logic                       i_local_ready,
  output logic [PKT_W-1:0]           o_up_data,
  output logic                       o_up_valid,
  input  logic                       i_up_ready,
  output logic [$clog2(fifoDepth):0] o_occupancy,
  output logic [CNT_W-1:0]           o_local_cnt,
  output logic [CNT_W-1:0]           o_up_cnt
);
  localparam int LO_I = clusterBase;
  localparam int HI_I = clusterBase + clusterSize;
  localparam logic [DEST_W:0] LOC_LO = LO_I[DEST_W:0];
  localparam logic [DEST_W:0] LOC_HI = HI_I[DEST_W:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PKT_W-1:0] head_raw;
  hnoc_pkt_t        head_pkt;
  logic             full, empty, is_local, local_pop, up_pop;
  logic [DEST_W:0]  dest_ext;

  hnoc_fifo #(.DATA_W(PKT_W), .DEPTH(fifoDepth)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (i_data_valid),
    .wr_data   (i_data),
    .rd_en     (local_pop | up_pop),
    .rd_data   (head_raw),
    .occupancy (o_occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign head_pkt     = head_raw;
  assign o_data_ready = ~full;

  assign dest_ext = {1'b0, head_pkt.dest};
  assign is_local = (dest_ext >= LOC_LO) && (dest_ext < LOC_HI);

  assign o_local_valid = ~empty & is_local;
  assign o_up_valid    = ~empty & ~is_local;
  // Zero the head while empty so stale storage never shows on the ports.
  assign o_local_data  = empty ? '0 : head_pkt;
  assign o_up_data     = empty ? '0 : head_pkt;

  assign local_pop = o_local_valid & i_local_ready;
  assign up_pop    = o_up_valid & i_up_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_local_cnt <= '0;
      o_up_cnt    <= '0;
    end else begin
      if (local_pop) o_local_cnt <= sat_inc(o_local_cnt);
      if (up_pop)    o_up_cnt    <= sat_inc(o_up_cnt);
    end
  end
endmodule

// File: tb/tb_hnoc_ingress.sv
// Directed bench for hnoc_ingress: routing, full/backpressure, HOL order,
// a randomised 100-packet stream against a queue model, and async reset.
module tb_hnoc_ingress;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [31:0] o_local_data;
  logic        o_local_valid;
  logic        i_local_ready;
  logic [31:0] o_up_data;
  logic        o_up_valid;
  logic        i_up_ready;
  logic [2:0]  o_occupancy;
  logic [15:0] o_local_cnt;
  logic [15:0] o_up_cnt;

  int n_chk = 0;
  int n_err = 0;

  hnoc_ingress #(.fifoDepth(4), .clusterBase(0), .clusterSize(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_data        (i_data),
    .i_data_valid  (i_data_valid),
    .o_data_ready  (o_data_ready),
    .o_local_data  (o_local_data),
    .o_local_valid (o_local_valid),
    .i_local_ready (i_local_ready),
    .o_up_data     (o_up_data),
    .o_up_valid    (o_up_valid),
    .i_up_ready    (i_up_ready),
    .o_occupancy   (o_occupancy),
    .o_local_cnt   (o_local_cnt),
    .o_up_cnt      (o_up_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] pkt);
    i_data       = pkt;
    i_data_valid = 1'b1;
    tick();
    i_data_valid = 1'b0;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  {31'd0, o_data_ready},  32'd1);
    chk({tag, "_lvalid"}, {31'd0, o_local_valid}, 32'd0);
    chk({tag, "_uvalid"}, {31'd0, o_up_valid},    32'd0);
    chk({tag, "_occ"},    {29'd0, o_occupancy},   32'd0);
    chk({tag, "_lcnt"},   {16'd0, o_local_cnt},   32'd0);
    chk({tag, "_ucnt"},   {16'd0, o_up_cnt},      32'd0);
    chk({tag, "_ldata"},  o_local_data,           32'd0);
    chk({tag, "_udata"},  o_up_data,              32'd0);
  endtask

  logic [31:0] pkts [100];
  logic [31:0] exp_q [$];
  logic [31:0] want;
  int sent, got, cyc, n_loc, n_up;

  initial begin
    rst = 1'b0; i_data = '0; i_data_valid = 1'b0;
    i_local_ready = 1'b0; i_up_ready = 1'b0;
    #12;
    chk_reset_vals("reset");
    rst = 1'b1;
    tick();

    // Single local packet
    push_one(32'h02000005);
    chk("loc_valid", {31'd0, o_local_valid}, 32'd1);
    chk("loc_upv",   {31'd0, o_up_valid},    32'd0);
    chk("loc_data",  o_local_data,           32'h02000005);
    chk("loc_occ",   {29'd0, o_occupancy},   32'd1);
    i_local_ready = 1'b1;
    tick();
    i_local_ready = 1'b0;
    chk("loc_cnt",   {16'd0, o_local_cnt},   32'd1);
    chk("loc_after", {31'd0, o_local_valid}, 32'd0);
    chk("loc_ucnt",  {16'd0, o_up_cnt},      32'd0);

    // Single uplink packet
    push_one(32'h070000AA);
    chk("up_valid", {31'd0, o_up_valid},    32'd1);
    chk("up_lv",    {31'd0, o_local_valid}, 32'd0);
    chk("up_data",  o_up_data,              32'h070000AA);
    i_up_ready = 1'b1;
    tick();
    i_up_ready = 1'b0;
    chk("up_cnt", {16'd0, o_up_cnt}, 32'd1);
    chk("up_occ", {29'd0, o_occupancy}, 32'd0);

    // Fill to full, fifth push held off until the first pop
    for (int i = 0; i < 4; i++) begin
      i_data = 32'h01000100 + i; i_data_valid = 1'b1;
      tick();
    end
    chk("full_occ",   {29'd0, o_occupancy},  32'd4);
    chk("full_ready", {31'd0, o_data_ready}, 32'd0);
    i_data = 32'h01000104;
    tick();
    chk("full_refuse", {29'd0, o_occupancy}, 32'd4);
    i_local_ready = 1'b1;
    #1;
    chk("drain0", o_local_data, 32'h01000100);
    tick();
    chk("pop_occ",   {29'd0, o_occupancy},  32'd3);
    chk("pop_ready", {31'd0, o_data_ready}, 32'd1);
    chk("drain1",    o_local_data,          32'h01000101);
    tick();
    i_data_valid = 1'b0;
    chk("pp_occ", {29'd0, o_occupancy}, 32'd3);
    for (int i = 2; i < 5; i++) begin
      chk("drain_n", o_local_data, 32'h01000100 + i);
      tick();
    end
    i_local_ready = 1'b0;
    chk("drain_occ", {29'd0, o_occupancy}, 32'd0);
    chk("drain_cnt", {16'd0, o_local_cnt}, 32'd6);

    // Head-of-line blocking
    push_one(32'h05000011);
    push_one(32'h01000022);
    i_local_ready = 1'b1;
    tick(); tick();
    chk("hol_lv",  {31'd0, o_local_valid}, 32'd0);
    chk("hol_uv",  {31'd0, o_up_valid},    32'd1);
    chk("hol_occ", {29'd0, o_occupancy},   32'd2);
    chk("hol_lc",  {16'd0, o_local_cnt},   32'd6);
    i_up_ready = 1'b1;
    tick();
    i_up_ready = 1'b0;
    chk("hol_next", o_local_data, 32'h01000022);
    chk("hol_nv",   {31'd0, o_local_valid}, 32'd1);
    tick();
    i_local_ready = 1'b0;
    chk("hol_lc2", {16'd0, o_local_cnt}, 32'd7);
    chk("hol_uc2", {16'd0, o_up_cnt},    32'd2);

    // Randomised stream against a queue model
    rst = 1'b0; #3; rst = 1'b1;
    tick();
    for (int i = 0; i < 100; i++)
      pkts[i] = {5'd0, 3'($urandom_range(0, 7)), 8'h5A, 16'(i)};
    sent = 0; got = 0; cyc = 0; n_loc = 0; n_up = 0;
    while (got < 100 && cyc < 3000) begin
      i_data_valid  = (sent < 100);
      i_data        = (sent < 100) ? pkts[sent] : 32'd0;
      i_local_ready = 1'($urandom);
      i_up_ready    = 1'($urandom);
      #1;
      if (o_local_valid && o_up_valid) chk("both_valid", 32'd1, 32'd0);
      if ((o_local_valid && i_local_ready) || (o_up_valid && i_up_ready)) begin
        want = exp_q.pop_front();
        if (want[31:24] < 8'd4) begin
          chk("str_port_l", {31'd0, o_local_valid}, 32'd1);
          chk("str_data_l", o_local_data, want);
          n_loc++;
        end else begin
          chk("str_port_u", {31'd0, o_up_valid}, 32'd1);
          chk("str_data_u", o_up_data, want);
          n_up++;
        end
        got++;
      end
      if (i_data_valid && o_data_ready) begin
        exp_q.push_back(pkts[sent]);
        sent++;
      end
      tick();
      cyc++;
    end
    i_data_valid = 1'b0; i_local_ready = 1'b0; i_up_ready = 1'b0;
    chk("str_done", got, 32'd100);
    chk("str_sum",  32'(o_local_cnt) + 32'(o_up_cnt), 32'd100);
    chk("str_lcnt", {16'd0, o_local_cnt}, n_loc);
    chk("str_ucnt", {16'd0, o_up_cnt},    n_up);

    // Asynchronous reset with packets in flight
    push_one(32'h01000031);
    push_one(32'h06000032);
    push_one(32'h02000033);
    chk("mid_occ", {29'd0, o_occupancy}, 32'd3);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("async");
    #2;
    rst = 1'b1;
    tick();
    push_one(32'h03000044);
    chk("post_data", o_local_data, 32'h03000044);
    i_local_ready = 1'b1;
    tick();
    i_local_ready = 1'b0;
    chk("post_lcnt", {16'd0, o_local_cnt}, 32'd1);
    chk("post_ucnt", {16'd0, o_up_cnt},    32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
